// File: rtl/idm_arbiter.sv
// Arbiter for the unified instruction/data memory: grants one of debug, load/store or fetch,
// then runs a registered ACCESS/DONE transaction and returns data with a one-cycle valid.
module idm_arbiter #(
    parameter int AW           = 8,
    parameter int WW           = 8,
    parameter int RW           = 16,
    parameter int DEPTH        = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          if_req_i,
    input  logic [AW-1:0] if_addr_i,
    output logic          if_gnt_o,
    output logic          if_rvalid_o,
    output logic [RW-1:0] if_rdata_o,
    input  logic          ls_req_i,
    input  logic          ls_we_i,
    input  logic [AW-1:0] ls_addr_i,
    input  logic [WW-1:0] ls_wdata_i,
    output logic          ls_gnt_o,
    output logic          ls_rvalid_o,
    output logic [RW-1:0] ls_rdata_o,
    input  logic          dbg_req_i,
    input  logic          dbg_we_i,
    input  logic [AW-1:0] dbg_addr_i,
    input  logic [WW-1:0] dbg_wdata_i,
    output logic          dbg_gnt_o,
    output logic          dbg_rvalid_o,
    output logic [RW-1:0] dbg_rdata_o,
    output logic          err_o,
    output logic [AW-1:0] mem_a_o,
    output logic [WW-1:0] mem_wd_o,
    output logic          mem_we_o,
    input  logic [RW-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;
    typedef enum logic [1:0] {PORT_IF, PORT_LS, PORT_DBG} port_e;

    localparam int            SW     = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] SLimit = SW'(STARVE_LIMIT);
    localparam logic [AW:0]   DepthL = (AW + 1)'(DEPTH);

    state_e        state_q, state_d;
    port_e         port_q, port_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          we_q, we_d;
    logic [WW-1:0] wdata_q, wdata_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [RW-1:0] if_rdata_q, ls_rdata_q, dbg_rdata_q;

    logic arbOpen, anyReq, ifStarved, inRange, inAccess, inDone;

    assign anyReq    = if_req_i | ls_req_i | dbg_req_i;
    assign ifStarved = if_req_i && (starve_q == SLimit);
    assign inRange   = {1'b0, addr_q} < DepthL;
    assign inAccess  = (state_q == ACCESS);
    assign inDone    = (state_q == DONE);
    // Grants are combinational from req, so they are masked while reset is held.
    assign arbOpen   = rst_ni && (state_q != ACCESS);

    always_comb begin
        state_d   = (state_q == ACCESS) ? DONE : IDLE;
        port_d    = port_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        starve_d  = starve_q;
        if_gnt_o  = 1'b0;
        ls_gnt_o  = 1'b0;
        dbg_gnt_o = 1'b0;
        if (arbOpen && anyReq) begin
            state_d = ACCESS;
            if (dbg_req_i) begin
                dbg_gnt_o = 1'b1;
                port_d    = PORT_DBG;
                addr_d    = dbg_addr_i;
                we_d      = dbg_we_i;
                wdata_d   = dbg_wdata_i;
            end else if (ls_req_i && !ifStarved) begin
                ls_gnt_o = 1'b1;
                port_d   = PORT_LS;
                addr_d   = ls_addr_i;
                we_d     = ls_we_i;
                wdata_d  = ls_wdata_i;
            end else begin
                if_gnt_o = 1'b1;
                port_d   = PORT_IF;
                addr_d   = if_addr_i;
                we_d     = 1'b0;
                wdata_d  = '0;
            end
            if (if_req_i && !if_gnt_o) begin
                starve_d = (starve_q == SLimit) ? starve_q : starve_q + SW'(1);
            end else begin
                starve_d = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            port_q      <= PORT_IF;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            starve_q    <= '0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state_q  <= state_d;
            port_q   <= port_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            starve_q <= starve_d;
            // Out-of-range reads return zero rather than whatever the memory aliases to.
            if (inAccess && !we_q) begin
                case (port_q)
                    PORT_IF:  if_rdata_q  <= inRange ? mem_rdata_i : '0;
                    PORT_LS:  ls_rdata_q  <= inRange ? mem_rdata_i : '0;
                    PORT_DBG: dbg_rdata_q <= inRange ? mem_rdata_i : '0;
                    default:  ;
                endcase
            end
        end
    end

    assign mem_a_o      = inAccess ? addr_q : '0;
    assign mem_wd_o     = inAccess ? wdata_q : '0;
    assign mem_we_o     = inAccess && we_q && inRange;
    assign if_rvalid_o  = inDone && (port_q == PORT_IF);
    assign ls_rvalid_o  = inDone && (port_q == PORT_LS);
    assign dbg_rvalid_o = inDone && (port_q == PORT_DBG);
    assign err_o        = inDone && !inRange;
    assign if_rdata_o   = if_rdata_q;
    assign ls_rdata_o   = ls_rdata_q;
    assign dbg_rdata_o  = dbg_rdata_q;

endmodule

// File: tb/tb_idm_arbiter.sv
// Scoreboard bench for idm_arbiter: stimulus pushes hand-computed responses, a negedge
// monitor pops and compares them whenever an rvalid appears.
module tb_idm_arbiter;

    typedef struct {
        logic [1:0]  port;
        logic [15:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, ls_req, ls_we, dbg_req, dbg_we;
    logic [7:0]  if_addr, ls_addr, ls_wdata, dbg_addr, dbg_wdata;
    logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid, dbg_gnt, dbg_rvalid, err;
    logic [15:0] if_rdata, ls_rdata, dbg_rdata, mem_rdata;
    logic [7:0]  mem_a, mem_wd;
    logic        mem_we;

    logic [15:0] memData [256];
    logic        memWritten [256];

    exp_t        expQ[$];
    logic [15:0] lastRd [3];
    int          vectors = 0;
    int          miscompares = 0;

    idm_arbiter dut (
        .clk_i(clk), .rst_ni(rst_n),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
        .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
        .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_addr_i(ls_addr), .ls_wdata_i(ls_wdata),
        .ls_gnt_o(ls_gnt), .ls_rvalid_o(ls_rvalid), .ls_rdata_o(ls_rdata),
        .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
        .dbg_gnt_o(dbg_gnt), .dbg_rvalid_o(dbg_rvalid), .dbg_rdata_o(dbg_rdata),
        .err_o(err), .mem_a_o(mem_a), .mem_wd_o(mem_wd), .mem_we_o(mem_we),
        .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] initVal(input logic [7:0] a);
        case (a)
            8'd3:    return 16'hC338;
            8'd5:    return 16'hA5A5;
            8'd70:   return 16'hBEEF;
            default: return {8'h5E, a};
        endcase
    endfunction

    always_comb mem_rdata = memWritten[mem_a] ? memData[mem_a] : initVal(mem_a);

    always @(posedge clk) begin
        if (mem_we) begin
            memData[mem_a]    <= {8'h00, mem_wd};
            memWritten[mem_a] <= 1'b1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic getGnt(input int p);
        return (p == 0) ? if_gnt : (p == 1) ? ls_gnt : dbg_gnt;
    endfunction

    function automatic logic getRvalid(input int p);
        return (p == 0) ? if_rvalid : (p == 1) ? ls_rvalid : dbg_rvalid;
    endfunction

    task automatic pushRead(input int p, input logic [15:0] data, input logic e);
        exp_t x;
        x.port = 2'(p); x.data = data; x.err = e;
        lastRd[p] = data;
        expQ.push_back(x);
    endtask

    task automatic pushWrite(input int p, input logic e);
        exp_t x;
        x.port = 2'(p); x.data = lastRd[p]; x.err = e;
        expQ.push_back(x);
    endtask

    task automatic setReq(input int p, input logic r, input logic w, input logic [7:0] a,
                          input logic [7:0] d);
        case (p)
            0: begin if_req = r; if_addr = a; end
            1: begin ls_req = r; ls_we = w; ls_addr = a; ls_wdata = d; end
            default: begin dbg_req = r; dbg_we = w; dbg_addr = a; dbg_wdata = d; end
        endcase
    endtask

    task automatic dropAll();
        if_req = 1'b0; ls_req = 1'b0; dbg_req = 1'b0;
    endtask

    task automatic resetDut();
        dropAll();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) lastRd[i] = '0;
        @(posedge clk);
        #1;
    endtask

    // Lone access from an idle arbiter: gnt at T, memory pins at T+1, rvalid at T+2.
    task automatic applyStimulus(input int p, input logic w, input logic [7:0] a,
                                 input logic [7:0] d);
        setReq(p, 1'b1, w, a, d);
        @(negedge clk);
        checkOutput("gnt_T", 32'(getGnt(p)), 1);
        @(posedge clk);
        #1;
        setReq(p, 1'b0, w, a, d);
        @(negedge clk);
        checkOutput("mem_a_T1", 32'(mem_a), 32'(a));
        checkOutput("mem_we_T1", 32'(mem_we), 32'(w && (a < 8'd64)));
        if (w) checkOutput("mem_wd_T1", 32'(mem_wd), 32'(d));
        @(negedge clk);
        checkOutput("rvalid_T2", 32'(getRvalid(p)), 1);
        checkOutput("mem_we_T2", 32'(mem_we), 0);
        @(posedge clk);
        #1;
    endtask

    int          rvCnt, gntCnt;
    exp_t        popped;
    logic [1:0]  actPort;
    logic [15:0] actData;

    always @(negedge clk) begin
        gntCnt = int'(if_gnt) + int'(ls_gnt) + int'(dbg_gnt);
        rvCnt  = int'(if_rvalid) + int'(ls_rvalid) + int'(dbg_rvalid);
        if (gntCnt != 0) checkOutput("gnt_onehot", 32'(gntCnt), 1);
        if (rvCnt != 0) begin
            checkOutput("rvalid_onehot", 32'(rvCnt), 1);
            if (expQ.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_rvalid: got rvalid with empty queue, expected none at %0t", $time);
            end else begin
                popped  = expQ.pop_front();
                actPort = dbg_rvalid ? 2'd2 : ls_rvalid ? 2'd1 : 2'd0;
                actData = dbg_rvalid ? dbg_rdata : ls_rvalid ? ls_rdata : if_rdata;
                checkOutput("resp_port", 32'(actPort), 32'(popped.port));
                checkOutput("resp_rdata", 32'(actData), 32'(popped.data));
                checkOutput("resp_err", 32'(err), 32'(popped.err));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int grants;
        rst_n = 1'b0;
        dropAll();
        ls_we = 0; dbg_we = 0;
        if_addr = 0; ls_addr = 0; ls_wdata = 0; dbg_addr = 0; dbg_wdata = 0;
        resetDut();

        // Fetch of word 3.
        pushRead(0, 16'hC338, 1'b0);
        applyStimulus(0, 1'b0, 8'd3, 8'h00);
        checkOutput("if_rdata_hold", 32'(if_rdata), 32'h0000C338);

        // Reset with every request raised, then dbg wins first after release.
        rst_n = 1'b0;
        setReq(0, 1'b1, 1'b0, 8'd3, 8'h00);
        setReq(1, 1'b1, 1'b0, 8'd5, 8'h00);
        setReq(2, 1'b1, 1'b0, 8'd3, 8'h00);
        #3;
        checkOutput("rst_mem_we", 32'(mem_we), 0);
        @(negedge clk);
        checkOutput("rst_gnts", {29'd0, if_gnt, ls_gnt, dbg_gnt}, 0);
        checkOutput("rst_rvalids", {28'd0, if_rvalid, ls_rvalid, dbg_rvalid, err}, 0);
        checkOutput("rst_if_rdata", 32'(if_rdata), 0);
        checkOutput("rst_mem_pins", {15'd0, mem_a, mem_wd, mem_we}, 0);
        for (int i = 0; i < 3; i++) lastRd[i] = '0;
        pushRead(2, 16'hC338, 1'b0);
        rst_n = 1'b1;
        #1;
        checkOutput("first_gnt", {29'd0, if_gnt, ls_gnt, dbg_gnt}, 32'b001);
        @(posedge clk);
        #1;
        dropAll();
        repeat (3) @(posedge clk);
        #1;

        // ls and if held together: four ls grants, then the starved fetch.
        resetDut();
        for (int k = 0; k < 10; k++) begin
            if (k % 5 == 4) pushRead(0, 16'hC338, 1'b0);
            else            pushRead(1, 16'hA5A5, 1'b0);
        end
        setReq(0, 1'b1, 1'b0, 8'd3, 8'h00);
        setReq(1, 1'b1, 1'b0, 8'd5, 8'h00);
        grants = 0;
        for (int c = 0; c < 40 && grants < 10; c++) begin
            @(negedge clk);
            if (if_gnt || ls_gnt) grants++;
        end
        checkOutput("starve_grant_count", 32'(grants), 10);
        @(posedge clk);
        #1;
        dropAll();
        repeat (4) @(posedge clk);
        #1;

        // Debug write beats ls and if; ls then reads the written word back.
        resetDut();
        pushWrite(2, 1'b0);
        pushRead(1, 16'h0014, 1'b0);
        setReq(2, 1'b1, 1'b1, 8'd56, 8'h14);
        setReq(1, 1'b1, 1'b0, 8'd56, 8'h00);
        setReq(0, 1'b1, 1'b0, 8'd3, 8'h00);
        @(negedge clk);
        checkOutput("dbg_first", {29'd0, if_gnt, ls_gnt, dbg_gnt}, 32'b001);
        @(posedge clk);
        #1;
        dbg_req = 1'b0;
        @(negedge clk);
        checkOutput("dbg_mem_pins", {15'd0, mem_a, mem_wd, mem_we}, {15'd0, 8'd56, 8'h14, 1'b1});
        @(negedge clk);
        checkOutput("ls_after_dbg", {29'd0, if_gnt, ls_gnt, dbg_gnt}, 32'b010);
        checkOutput("dbg_we_1cycle", 32'(mem_we), 0);
        @(posedge clk);
        #1;
        dropAll();
        repeat (3) @(posedge clk);
        #1;
        pushRead(1, 16'h0014, 1'b0);
        applyStimulus(1, 1'b0, 8'd56, 8'h00);

        // Out-of-range read and write on ls.
        pushRead(1, 16'h0000, 1'b1);
        applyStimulus(1, 1'b0, 8'd70, 8'h00);
        pushWrite(1, 1'b1);
        applyStimulus(1, 1'b1, 8'd70, 8'h77);

        // Reset mid-ACCESS of an ls write: mem_we drops with no edge, no response later.
        setReq(1, 1'b1, 1'b1, 8'd10, 8'h5A);
        @(negedge clk);
        checkOutput("abort_gnt", 32'(ls_gnt), 1);
        @(posedge clk);
        #1;
        dropAll();
        #1;
        checkOutput("abort_we_before", 32'(mem_we), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_we_async", 32'(mem_we), 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("queue_empty", 32'(expQ.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
